iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage.
- Replaces the fixed 32-bit signed/unsigned vendor divider pair with one unit of configurable width.
- Computes quotient and remainder in one pass, with a runtime signed/unsigned mode select.
- Uses a valid/ready handshake on both sides, carries a tag, and supports pipeline flush with defined divide-by-zero results.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- TAG_W, 5, width of the passthrough tag, e.g. the destination register number.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous cancel of any in-flight or held operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; combinational from state and out_ready.
- in_signed  in  1  1 = two's-complement divide, 0 = unsigned.
- in_dividend  in  WIDTH  dividend.
- in_divisor  in  WIDTH  divisor.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_quotient  out  WIDTH  quotient.
- out_remainder  out  WIDTH  remainder.
- out_tag  out  TAG_W  tag of the result.
- out_div_zero  out  1  divisor was zero.
- busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset puts the unit in IDLE.
- Reset values: out_valid=0, busy=0, out_quotient/out_remainder/out_tag/out_div_zero=0, iteration counter=0. Reset takes effect immediately on the resetn falling edge, including mid-operation.
- in_ready = (state==IDLE) || (state==DONE && out_ready), and is forced to 0 while flush=1.
- Accept occurs on an edge with in_valid && in_ready && !flush:
  - latch operands, mode, tag and div_zero = (divisor==0);
  - in signed mode, latch |dividend|, |divisor| and the signs; otherwise latch raw values;
  - clear the partial remainder; set the counter to WIDTH-1; go to CALC.
- CALC performs one restoring iteration per edge:
  - shift {rem, quo} left by 1;
  - trial-subtract |divisor| (WIDTH+1-bit compare); on no borrow, set the quotient LSB and keep the difference;
  - decrement the counter; when the counter is 0, go to FIX.
- FIX lasts one edge and applies the sign and zero corrections:
  - signed: quotient negated if sign(a) XOR sign(b); remainder negated if sign(a).
  - divisor==0 (either mode): quotient = all ones, remainder = original dividend, out_div_zero=1.
  - Result is then registered to the outputs; go to DONE.
- Latency is fixed at WIDTH+1 edges from the accept edge to out_valid=1, independent of operands (33 for WIDTH=32).
- DONE:
  - out_valid=1; outputs stay stable while out_ready=0.
  - On out_ready, the result is consumed. With a simultaneous accept, go to CALC with the new operation (back-to-back); otherwise go to IDLE.
  - Throughput is one op per WIDTH+1 cycles.
- Overflow, MIN / -1 (signed): the magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits. Result is quotient = MIN, remainder = 0, with no flag.
- Unsigned mode treats bit WIDTH-1 as magnitude; no negation applies.
- flush:
  - From any state, the next edge goes to IDLE with out_valid=0.
  - A held DONE result is discarded.
  - flush has priority over accept and over out_ready.
- Input operand ports are ignored outside accept edges; changing them mid-CALC has no effect.
- busy=1 in CALC/FIX/DONE.

Test Plan (WIDTH=32, TAG_W=5):
1. Unsigned, tag 5, out_ready=1: 100/7 -> q=14, r=2, out_tag=5, div_zero=0. out_valid high exactly 33 cycles after the accept edge, for exactly 1 cycle.
2. Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
3. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0x80000000/0xFFFFFFFF -> q=0, r=0x80000000.
4. Divide by zero:
   - 0x1234/0 in both modes -> q=0xFFFFFFFF, r=0x1234, div_zero=1.
   - Signed -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid and all outputs stable, in_ready=0.
   - Raise out_ready with in_valid=1 -> the new op is accepted the same edge and its result arrives 33 cycles later.
6. Cancellation:
   - flush on the 10th CALC cycle -> no out_valid ever for that op; a new op accepted on the following cycle returns the correct result.
   - flush while in DONE with out_ready=0 -> result dropped.
   - resetn pulsed low mid-CALC -> out_valid=0 and busy=0 immediately, before any clock edge.

Source files
------------

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle restoring integer divider, one quotient bit per edge.
// Computes quotient and remainder together with runtime signed/unsigned select.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   flush               synchronous cancel of any in-flight or held operation
//   in_valid/in_ready   request handshake (in_ready combinational)
//   in_signed           1 = two's-complement divide, 0 = unsigned
//   in_dividend/divisor operands, sampled only on the accept edge
//   in_tag              passthrough tag returned with the result
//   out_valid/out_ready result handshake
//   out_quotient/out_remainder/out_tag/out_div_zero  registered result
//   busy                unit is not idle
module iter_div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, dividend_raw;
  logic             sign_a, sign_b, sgn_mode, dz;
  logic [TAG_W-1:0] tag_r;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   trial;
  logic             fits;

  assign accept = in_valid && in_ready && !flush;

  // Magnitudes; |MIN| wraps to MIN, which is the correct unsigned magnitude.
  assign abs_a = (in_signed && in_dividend[WIDTH-1]) ? ('0 - in_dividend) : in_dividend;
  assign abs_b = (in_signed && in_divisor[WIDTH-1])  ? ('0 - in_divisor)  : in_divisor;

  // Shifted partial remainder, one bit wider so the compare never overflows.
  assign trial = {rem, quo[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dvs});

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    in_ready  = ((state == IDLE) || (state == DONE && out_ready)) && !flush;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      dividend_raw  <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      sgn_mode      <= 1'b0;
      dz            <= 1'b0;
      tag_r         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_div_zero  <= 1'b0;
    end else if (accept) begin
      cnt          <= CW'(WIDTH - 1);
      rem          <= '0;
      quo          <= abs_a;
      dvs          <= abs_b;
      dividend_raw <= in_dividend;
      sign_a       <= in_signed && in_dividend[WIDTH-1];
      sign_b       <= in_signed && in_divisor[WIDTH-1];
      sgn_mode     <= in_signed;
      dz           <= (in_divisor == '0);
      tag_r        <= in_tag;
    end else if (state == CALC && !flush) begin
      rem <= fits ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !flush) begin
      if (dz) begin
        out_quotient  <= '1;
        out_remainder <= dividend_raw;
      end else begin
        out_quotient  <= (sgn_mode && (sign_a ^ sign_b)) ? ('0 - quo) : quo;
        out_remainder <= (sgn_mode && sign_a) ? ('0 - rem) : rem;
      end
      out_tag      <= tag_r;
      out_div_zero <= dz;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, in_signed;
  logic [31:0] in_dividend, in_divisor;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_quotient, out_remainder;
  logic [4:0]  out_tag;
  logic        out_div_zero, busy;

  int checks = 0;
  int errors = 0;

  iter_div_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_tag(out_tag), .out_div_zero(out_div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] q, r;
    bit          dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on sign-extended 64-bit values (truncating division).
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output bit dz);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Present an op and wait until it is accepted; operand ports are scrambled afterwards.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n;
    in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b; in_tag = tag;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_dividend = $urandom; in_divisor = $urandom; in_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        output logic [31:0] q, output logic [31:0] r, output logic [4:0] t, output bit dz);
    int lat;
    out_ready = 1'b1;
    issue(s, a, b, tag);
    wait_result(lat);
    check("latency", lat, 33);
    q = out_quotient; r = out_remainder; t = out_tag; dz = out_div_zero;
    @(posedge clk); #1;
    check("valid_one_cycle", out_valid, 0);
  endtask

  initial begin
    vec_t        vecs[9];
    logic [31:0] q, r, eq, er, hq, hr;
    logic [4:0]  t, ht;
    bit          dz, edz, s;
    logic [31:0] a, b;
    logic [4:0]  tag;
    int          lat, seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        5'd5,  32'd14,       32'd2,        1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        5'd1,  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 5'd2,  32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3] = '{1'b0, 32'hFFFFFFF9,   32'd2,        5'd3,  32'h7FFFFFFC, 32'd1,        1'b0};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 5'd4,  32'h80000000, 32'd0,        1'b0};
    vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 5'd6,  32'd0,        32'h80000000, 1'b0};
    vecs[6] = '{1'b0, 32'h1234,       32'd0,        5'd7,  32'hFFFFFFFF, 32'h1234,     1'b1};
    vecs[7] = '{1'b1, 32'h1234,       32'd0,        5'd8,  32'hFFFFFFFF, 32'h1234,     1'b1};
    vecs[8] = '{1'b1, 32'hFFFFFFFB,   32'd0,        5'd31, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quotient", out_quotient, 0);
    check("rst_remainder", out_remainder, 0);
    check("rst_tag_dz", {out_tag, out_div_zero}, 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].tag, q, r, t, dz);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_tag", i), t, vecs[i].tag);
      check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
    end

    // Backpressure, then back-to-back accept on the consuming edge
    out_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd33, 5'd9);
    wait_result(lat);
    check("bp_latency", lat, 33);
    hq = out_quotient; hr = out_remainder; ht = out_tag;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_stable", {out_quotient, out_remainder}, {hq, hr});
      check("bp_tag_stable", out_tag, ht);
    end
    check("bp_q", hq, 32'd30);
    check("bp_r", hr, 32'd10);
    in_valid = 1'b1; in_signed = 1'b1; in_dividend = 32'hFFFFFF9C; in_divisor = 32'd7; in_tag = 5'd10;
    out_ready = 1'b1;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_dividend = $urandom;
    check("b2b_valid_drop", out_valid, 0);
    check("b2b_busy", busy, 1);
    wait_result(lat);
    check("b2b_latency", lat, 33);
    check("b2b_q", out_quotient, 32'hFFFFFFF2);   // -100/7 = -14
    check("b2b_r", out_remainder, 32'hFFFFFFFE);  // remainder -2
    check("b2b_tag", out_tag, 5'd10);
    @(posedge clk); #1;

    // Flush on the 10th CALC cycle
    issue(1'b0, 32'd5000, 32'd3, 5'd11);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    run_op(1'b1, 32'hFFFFF000, 32'd16, 5'd12, q, r, t, dz);
    check("post_flush_q", q, 32'hFFFFFF00);
    check("post_flush_r", r, 32'd0);
    check("post_flush_tag", t, 5'd12);

    // Flush while holding a DONE result; flush beats accept and out_ready
    out_ready = 1'b0;
    issue(1'b0, 32'd77, 32'd5, 5'd13);
    wait_result(lat);
    check("hold_latency", lat, 33);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    #1 check("flush_done_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_done_no_result", seen, 0);

    // Asynchronous reset mid-CALC
    issue(1'b0, 32'd999, 32'd9, 5'd14);
    repeat (5) begin @(posedge clk); #1; end
    #1 resetn = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_q", out_quotient, 0);
    @(posedge clk); #1 resetn = 1'b1;
    run_op(1'b0, 32'd999, 32'd9, 5'd14, q, r, t, dz);
    check("after_rst_q", q, 32'd111);
    check("after_rst_r", r, 32'd0);

    // Randomized against the arithmetic reference
    for (int i = 0; i < 150; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      tag = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = '1;
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, eq, er, edz);
      run_op(s, a, b, tag, q, r, t, dz);
      check($sformatf("rnd%0d_q", i), q, eq);
      check($sformatf("rnd%0d_r", i), r, er);
      check($sformatf("rnd%0d_tag", i), t, tag);
      check($sformatf("rnd%0d_dz", i), dz, edz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
